// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: round-robin ties, bounded
// back-to-back lock for requester 1, one access per two cycles, read data returned next cycle.
module ram_port_arbiter #(
    parameter int unsigned A_WIDTH    = 12,
    parameter int unsigned LOCK_LIMIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               r0Request,
    input  logic               r0Write,
    input  logic [A_WIDTH-1:0] r0Address,
    input  logic [31:0]        r0WriteData,
    input  logic [3:0]         r0ByteEnable,
    output logic               r0Grant,
    output logic               r0ReadValid,
    output logic [31:0]        r0ReadData,
    input  logic               r1Request,
    input  logic               r1Write,
    input  logic [A_WIDTH-1:0] r1Address,
    input  logic [31:0]        r1WriteData,
    input  logic [3:0]         r1ByteEnable,
    output logic               r1Grant,
    output logic               r1ReadValid,
    output logic [31:0]        r1ReadData,
    input  logic               r1Lock,
    output logic [A_WIDTH-1:0] ramAddress,
    output logic [31:0]        ramWriteData,
    output logic [3:0]         ramByteEnable,
    output logic               ramWriteEnable,
    input  logic [31:0]        ramReadData
);

    localparam logic [3:0] LockLimit = 4'(LOCK_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StAccess0,
        StAccess1
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         lock_cnt_q, lock_cnt_d;
    logic               wr_q, wr_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               rv0_q, rv0_d;
    logic               rv1_q, rv1_d;

    logic pick0, pick1, lock_hit;
    logic in_access0, in_access1;

    always_comb begin
        pick0    = 1'b0;
        pick1    = 1'b0;
        lock_hit = 1'b0;
        if (state_q == StIdle) begin
            if (r0Request && r1Request) begin
                lock_hit = r1Lock && last_grant_q && (lock_cnt_q < LockLimit);
                if (lock_hit) begin
                    pick1 = 1'b1;
                end else if (last_grant_q) begin
                    pick0 = 1'b1;
                end else begin
                    pick1 = 1'b1;
                end
            end else if (r0Request) begin
                pick0 = 1'b1;
            end else if (r1Request) begin
                pick1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rv0_d        = 1'b0;
        rv1_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick0) begin
                    state_d      = StAccess0;
                    last_grant_d = 1'b0;
                    lock_cnt_d   = 4'd0;
                    wr_d         = r0Write;
                    addr_d       = r0Address;
                    wdata_d      = r0WriteData;
                    be_d         = r0ByteEnable;
                end else if (pick1) begin
                    state_d      = StAccess1;
                    last_grant_d = 1'b1;
                    // Unlocked r1 grants restart the run; locked non-contended ones leave it alone.
                    if (lock_hit) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end else if (!r1Lock) begin
                        lock_cnt_d = 4'd0;
                    end
                    wr_d    = r1Write;
                    addr_d  = r1Address;
                    wdata_d = r1WriteData;
                    be_d    = r1ByteEnable;
                end
            end
            StAccess0: begin
                state_d = StIdle;
                rv0_d   = !wr_q;
            end
            StAccess1: begin
                state_d = StIdle;
                rv1_d   = !wr_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rv0_q        <= rv0_d;
            rv1_q        <= rv1_d;
        end
    end

    // Outputs are gated by reset so an in-flight access is squashed the moment reset drops.
    assign in_access0 = (state_q == StAccess0) && reset;
    assign in_access1 = (state_q == StAccess1) && reset;

    assign r0Grant        = in_access0;
    assign r1Grant        = in_access1;
    assign ramAddress     = reset ? addr_q : '0;
    assign ramWriteData   = reset ? wdata_q : 32'h0;
    assign ramByteEnable  = reset ? be_q : 4'h0;
    assign ramWriteEnable = (in_access0 || in_access1) && wr_q;

    assign r0ReadValid = rv0_q && reset;
    assign r1ReadValid = rv1_q && reset;
    assign r0ReadData  = r0ReadValid ? ramReadData : 32'h0;
    assign r1ReadData  = r1ReadValid ? ramReadData : 32'h0;

endmodule
